// File: rtl/grid_memory_port_arbiter.sv
// grid_memory_port_arbiter
// Shares one grid memory tile between two valid/ready requesters (A and B).
// Round-robin arbitration on contention, registered memory-side pins and a
// requester-tag pipeline that routes each read response back to its issuer.
// Optional zero-fill of the whole tile: define GRID_MEMORY_PORT_ARBITER_CLEAR_EN.

module grid_memory_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            state_r;
    logic              prio_b_r;
    logic [RD_LAT-1:0] tag_vld_r;
    logic [RD_LAT-1:0] tag_id_r;
    logic              a_rsp_valid_r;
    logic              b_rsp_valid_r;
    logic [DATA_W-1:0] a_rdata_hold_r;
    logic [DATA_W-1:0] b_rdata_hold_r;
    logic [ADDR_W-1:0] mem_waddr_r;
    logic [ADDR_W-1:0] mem_raddr_r;
    logic [DATA_W-1:0] mem_data_in_r;
    logic              mem_wen_r;
    logic              mem_ren_r;
    logic              clear_busy_r;
    logic              clear_done_r;

    logic              clear_go_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              accept_s;
    logic              acc_we_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;

`ifdef GRID_MEMORY_PORT_ARBITER_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] clr_cnt_r;
    logic              pipe_empty_s;

    // A clear request only counts while serving; it also blocks this cycle's grant.
    assign clear_go_s   = clear_start && (state_r == ST_SERVE);
    // No read is in flight once every tag stage and the response flops are idle.
    assign pipe_empty_s = (tag_vld_r == {RD_LAT{1'b0}}) && !a_rsp_valid_r && !b_rsp_valid_r;
`else
    logic unused_clear_s;

    assign unused_clear_s = clear_start;
    assign clear_go_s     = 1'b0;
`endif

    // Arbitration: a lone requester wins; on contention the priority holder wins.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if ((state_r == ST_SERVE) && !clear_go_s) begin
            if (a_req_valid && (!b_req_valid || !prio_b_r)) begin
                grant_a_s = 1'b1;
            end else if (b_req_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
            end
        end else begin
            grant_b_s = 1'b0;
        end
    end

    // Select the command of whichever requester was granted.
    always_comb begin
        accept_s = grant_a_s || grant_b_s;
        if (grant_b_s) begin
            acc_we_s    = b_req_we;
            acc_addr_s  = b_req_addr;
            acc_wdata_s = b_req_wdata;
        end else begin
            acc_we_s    = a_req_we;
            acc_addr_s  = a_req_addr;
            acc_wdata_s = a_req_wdata;
        end
    end

    assign a_req_ready = grant_a_s;
    assign b_req_ready = grant_b_s;

    // Control FSM: serve commands, drain in-flight reads, then zero-fill the tile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_SERVE;
            prio_b_r      <= 1'b0;
            mem_waddr_r   <= {ADDR_W{1'b0}};
            mem_raddr_r   <= {ADDR_W{1'b0}};
            mem_data_in_r <= {DATA_W{1'b0}};
            mem_wen_r     <= 1'b0;
            mem_ren_r     <= 1'b0;
            clear_busy_r  <= 1'b0;
            clear_done_r  <= 1'b0;
`ifdef GRID_MEMORY_PORT_ARBITER_CLEAR_EN
            clr_cnt_r     <= {ADDR_W{1'b0}};
`endif
        end else begin
            mem_wen_r    <= 1'b0;
            mem_ren_r    <= 1'b0;
            clear_done_r <= 1'b0;
            case (state_r)
                ST_SERVE: begin
                    if (accept_s) begin
                        if (acc_we_s) begin
                            mem_wen_r     <= 1'b1;
                            mem_waddr_r   <= acc_addr_s;
                            mem_data_in_r <= acc_wdata_s;
                        end else begin
                            mem_ren_r     <= 1'b1;
                            mem_raddr_r   <= acc_addr_s;
                        end
                    end else begin
                        mem_wen_r <= 1'b0;
                    end
                    // Priority only moves when the loser was actually waiting.
                    if (grant_a_s && b_req_valid) begin
                        prio_b_r <= 1'b1;
                    end else if (grant_b_s && a_req_valid) begin
                        prio_b_r <= 1'b0;
                    end else begin
                        prio_b_r <= prio_b_r;
                    end
`ifdef GRID_MEMORY_PORT_ARBITER_CLEAR_EN
                    if (clear_go_s) begin
                        state_r      <= ST_DRAIN;
                        clear_busy_r <= 1'b1;
                    end else begin
                        state_r      <= ST_SERVE;
                    end
`endif
                end
`ifdef GRID_MEMORY_PORT_ARBITER_CLEAR_EN
                ST_DRAIN: begin
                    if (pipe_empty_s) begin
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_CLEAR: begin
                    mem_wen_r     <= 1'b1;
                    mem_waddr_r   <= clr_cnt_r;
                    mem_data_in_r <= {DATA_W{1'b0}};
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r      <= ST_SERVE;
                        clear_busy_r <= 1'b0;
                        clear_done_r <= 1'b1;
                        clr_cnt_r    <= {ADDR_W{1'b0}};
                    end else begin
                        clr_cnt_r    <= clr_cnt_r + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                    state_r <= ST_SERVE;
                end
            endcase
        end
    end

    // Tag pipeline: carries "read issued by B" alongside each accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_r      <= {RD_LAT{1'b0}};
            tag_id_r       <= {RD_LAT{1'b0}};
            a_rsp_valid_r  <= 1'b0;
            b_rsp_valid_r  <= 1'b0;
            a_rdata_hold_r <= {DATA_W{1'b0}};
            b_rdata_hold_r <= {DATA_W{1'b0}};
        end else begin
            tag_vld_r[0] <= accept_s && !acc_we_s;
            tag_id_r[0]  <= grant_b_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
            a_rsp_valid_r <= tag_vld_r[RD_LAT-1] && !tag_id_r[RD_LAT-1];
            b_rsp_valid_r <= tag_vld_r[RD_LAT-1] && tag_id_r[RD_LAT-1];
            if (a_rsp_valid_r) begin
                a_rdata_hold_r <= mem_data_out;
            end else begin
                a_rdata_hold_r <= a_rdata_hold_r;
            end
            if (b_rsp_valid_r) begin
                b_rdata_hold_r <= mem_data_out;
            end else begin
                b_rdata_hold_r <= b_rdata_hold_r;
            end
        end
    end

    // Read data is only valid at the tile in the response cycle itself, so it is
    // passed through then and the captured copy is shown at all other times.
    assign a_rsp_valid = a_rsp_valid_r;
    assign b_rsp_valid = b_rsp_valid_r;
    assign a_rsp_rdata = a_rsp_valid_r ? mem_data_out : a_rdata_hold_r;
    assign b_rsp_rdata = b_rsp_valid_r ? mem_data_out : b_rdata_hold_r;

    assign mem_waddr   = mem_waddr_r;
    assign mem_raddr   = mem_raddr_r;
    assign mem_data_in = mem_data_in_r;
    assign mem_wen     = mem_wen_r;
    assign mem_ren     = mem_ren_r;
    assign clear_busy  = clear_busy_r;
    assign clear_done  = clear_done_r;

endmodule

// File: doc/grid_memory_port_arbiter.md
Name: grid_memory_port_arbiter

Overview:
- Shares one eFPGA memory tile (1024x8, separate waddr/raddr, wen/ren, single clk) between two fabric-side requesters, A and B.
- Requesters use a valid/ready handshake. Each accepted read returns a response tagged back to the requester that issued it.
- The block registers all memory-side pins and tracks read latency with a tag pipeline.
- Sits between the fabric routing and the grid memory tile.

Parameters:
ADDR_W, 10, address width; memory depth DEPTH = 2**ADDR_W
DATA_W, 8, data width
RD_LAT, 1, memory read latency in cycles from the mem_ren edge to valid mem_data_out; legal range 1..4

Ports:
clk  in  1  single clock for the block and the memory tile
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
a_req_valid  in  1  requester A has a command
a_req_ready  out  1  A's command is accepted this cycle
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  ADDR_W  command address
a_req_wdata  in  DATA_W  write data
a_rsp_valid  out  1  read data valid for A (single-cycle pulse)
a_rsp_rdata  out  DATA_W  read data for A
b_*  (same seven ports as A, for requester B)
clear_start  in  1  pulse that requests a zero-fill of the whole memory
clear_busy  out  1  clear sequence is in progress
clear_done  out  1  one-cycle pulse when the clear finishes
mem_waddr  out  ADDR_W  memory write address
mem_raddr  out  ADDR_W  memory read address
mem_data_in  out  DATA_W  memory write data
mem_wen  out  1  memory write enable, active-high
mem_ren  out  1  memory read enable, active-high
mem_data_out  in  DATA_W  memory read data

Behaviour:
- Reset: every output is 0, state = SERVE, round-robin priority = A, clear counter = 0, tag pipeline cleared. A reset mid-operation aborts any clear and drops any in-flight read; no response is produced for those reads.
- Acceptance: a command is accepted when x_req_valid && x_req_ready. At most one command is accepted per cycle across A and B.
- x_req_ready is combinational. It is 1 only in state SERVE, and only for the requester the arbiter selects:
  - only one requester valid: that requester is selected;
  - both valid: the requester holding priority is selected.
  - When the other requester was also valid, priority passes to it after the grant. When only one requester was valid, priority is unchanged.
- Memory drive: the accepted command is registered onto the mem_* pins on the next edge.
  - Write: mem_wen = 1, mem_waddr and mem_data_in are set.
  - Read: mem_ren = 1, mem_raddr is set.
  - Cycles with no acceptance: mem_wen = mem_ren = 0; address and data outputs hold their last value.
- Read responses:
  - A read accepted in cycle t produces x_rsp_valid = 1 in cycle t+1+RD_LAT, for exactly one cycle.
  - x_rsp_rdata = mem_data_out in that cycle. It holds its value outside the response cycle.
  - The response is routed by a 1-bit requester tag carried through a (1+RD_LAT)-deep pipeline.
  - Responses return in acceptance order. The bench does not apply backpressure on responses.
- Writes produce no response.
- Ordering: a write followed by a read to the same address returns the new data, because commands are serialized in acceptance order.
- State machine (SERVE / DRAIN / CLEAR):
  - SERVE -> DRAIN on clear_start when the clear feature is compiled in. clear_busy = 1 from the next cycle.
  - DRAIN: all readys are 0. Stays in DRAIN until the tag pipeline is empty, i.e. in-flight reads complete normally. Then -> CLEAR.
  - CLEAR: all readys are 0. Drives mem_wen = 1, mem_data_in = 0, mem_waddr = counter, for counter = 0 .. DEPTH-1, one address per cycle.
  - At the cycle with counter = DEPTH-1 -> SERVE; next cycle clear_busy = 0 and clear_done = 1 for one cycle.
  - The counter wraps to 0 at the end of the clear.
- clear_start is ignored outside SERVE.
- clear_start in the same cycle as a valid request: the request is not accepted (ready is forced to 0 in that cycle); the clear takes precedence.

Optional Feature:
GRID_MEMORY_PORT_ARBITER_CLEAR_EN
- Defined: the DRAIN/CLEAR states, the ADDR_W-bit counter, clear_busy and clear_done are implemented as described above.
- Undefined:
  - clear_start is ignored;
  - clear_busy and clear_done are tied to 0;
  - the state machine reduces to SERVE only;
  - the clear ports remain present.

Test Plan:
- Reset, then only A valid, writing 0xA5 to address 0x3FF: a_req_ready = 1; next cycle mem_wen = 1, mem_waddr = 0x3FF, mem_data_in = 0xA5, and mem_ren = 0.
- A reads address 0x3FF the cycle after that write (RD_LAT = 1): a_rsp_valid pulses 2 cycles after acceptance with rdata 0xA5; b_rsp_valid stays 0.
- A and B both continuously valid for 4 cycles: grants go A, B, A, B. With only B valid over three cycles, B is granted each cycle and priority is unchanged.
- Interleaved reads A@0x010, B@0x020, A@0x030 with RD_LAT = 3: responses arrive in cycles t+4, t+5 and t+6, routed A, B, A.
- Clear feature compiled in, with one read in flight when clear_start fires:
  - the read response is still delivered;
  - then 1024 consecutive zero writes to addresses 0..0x3FF;
  - clear_done pulses once, and readys stay 0 throughout;
  - a later read of 0x3FF returns 0x00.
- rst_n driven low at clear counter = 0x200: the next cycle shows state SERVE, all outputs 0 and clear_busy = 0; no clear_done is issued.
